alu_pipe_nbit: RTL and testbench
================================

// Module: alu_pipe_nbit
// PURPOSE
//  Parametrised, registered ALU; successor to the 16-bit ripple ALU. Adds valid/ready handshakes,
//  a correct Zero flag, XOR/SLT, and a multi-cycle shift-add multiplier. It sits between the
//  register-file read stage and writeback. It holds its result until the consumer accepts it.
// PARAMETERS
//  WIDTH  16  operand/result width in bits (>=4)
//  CNT_W  $clog2(WIDTH)+1  multiplier iteration counter width (derived; do not override)
// PORTS
//  clk        in   1      single clock, rising edge
//  reset      in   1      asynchronous, active-high; clears all state
//  in_valid   in   1      operand/opcode bundle valid
//  in_ready   out  1      block can accept a bundle this cycle
//  a          in   WIDTH  operand A
//  b          in   WIDTH  operand B
//  AInvert    in   1      use ~a (AND/OR/XOR/ADD only)
//  BNegate    in   1      use ~b and carry-in 1 (AND/OR/XOR/ADD only)
//  Op         in   3      000 AND, 001 OR, 010 ADD, 011 SLT, 100 MUL, 101 XOR, 11x reserved
//  out_valid  out  1      result/flags valid
//  out_ready  in   1      consumer accepts result this cycle
//  result     out  WIDTH  registered result
//  CarryOut   out  1      registered carry / MUL high-half-nonzero
//  Overflow   out  1      registered signed overflow
//  Zero       out  1      1 when result == 0
//  busy       out  1      high while a multiply is iterating
// BEHAVIOUR
//  Reset (async, immediate): state=IDLE; out_valid=0; result=0; CarryOut=0; Overflow=0;
//   Zero=1; busy=0. Any in-flight multiply is discarded; no output is produced for it.
//  Handshake: accept when in_valid&&in_ready. Result transfers when out_valid&&out_ready.
//   in_ready = (state==IDLE) && (!out_valid || out_ready). This allows one op/cycle back-to-back.
//   While out_valid=1 and out_ready=0, result and flags hold stable and no new bundle is taken.
//  Operand prep: A'=AInvert?~a:a; B'=BNegate?~b:b; cin=BNegate.
//  FSM IDLE -> (accept, Op!=MUL) -> IDLE: outputs are registered on the accept edge, so
//   out_valid rises 1 cycle after accept.
//  FSM IDLE -> (accept, Op==MUL) -> MUL: latch a, b; clear the 2*WIDTH accumulator; set cnt=0.
//   busy=1. Each cycle, if multiplier LSB is set, add the multiplicand to the accumulator;
//   shift the multiplicand left and the multiplier right; cnt++.
//   After WIDTH iterations -> IDLE, and load the outputs. out_valid rises WIDTH+1 cycles after
//   accept. A done-cycle load never collides with an unaccepted output (in_ready gating).
//  AND/OR/XOR: bitwise on A',B'. CarryOut=0, Overflow=0.
//  ADD: {c,s}=A'+B'+cin (WIDTH+1 bits). result=s; CarryOut=c;
//   Overflow=carry-into-MSB ^ carry-out-of-MSB. a-b is ADD with BNegate=1.
//  SLT: always computes a-b signed (AInvert/BNegate ignored). result={0..,sign^ovf};
//   CarryOut=0, Overflow=0.
//  MUL: unsigned, AInvert/BNegate ignored. result=prod[WIDTH-1:0];
//   CarryOut=|prod[2W-1:W]; Overflow=0.
//  Reserved Op: result=0, CarryOut=0, Overflow=0, Zero=1, still completes in 1 cycle.
//  Zero = ~|result_next, registered together with result (never out of step with it).
//  Outputs change only on a load or on reset. Inputs are not sampled when not accepted.
// TESTING
//  WIDTH=16. ADD a=7FFF b=0001 -> out_valid at +1 clk, result=8000, Overflow=1, CarryOut=0, Zero=0.
//  SUB (ADD,BNegate=1) a=0005 b=0005 -> result=0000, Zero=1, CarryOut=1, Overflow=0.
//  SLT a=FFFF b=0001 -> result=0001. SLT a=0001 b=FFFF -> result=0000.
//  MUL a=0100 b=0100: busy for 16 clk; out_valid at +17 -> result=0000, CarryOut=1, Zero=1.
//   MUL a=00FF b=0003 -> result=02FD, CarryOut=0.
//  Backpressure: hold out_ready=0 for 5 clk -> in_ready=0 and result stable.
//   Then issue 4 back-to-back ADDs with out_ready=1 -> 4 results on 4 consecutive cycles.
//  Assert reset at MUL iteration 8 -> out_valid=0, busy=0, Zero=1 immediately.
//   After release, next ADD 0002+0003 -> 0005.

Source files
------------

// File: rtl/alu_pipe_nbit.sv
// Registered ALU with valid/ready handshakes on both sides.
// Single-cycle AND/OR/XOR/ADD/SLT; a WIDTH-cycle shift-add multiplier for MUL.
// The result and flags are held until the consumer takes them.

module alu_pipe_nbit #(
    parameter int unsigned WIDTH = 16
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             AInvert,
    input  logic             BNegate,
    input  logic [2:0]       Op,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] result,
    output logic             CarryOut,
    output logic             Overflow,
    output logic             Zero,
    output logic             busy
);

    // Derived from WIDTH; not meant to be overridden.
    localparam int unsigned CNT_W = $clog2(WIDTH) + 1;

    localparam logic [2:0] OpAnd = 3'b000;
    localparam logic [2:0] OpOr  = 3'b001;
    localparam logic [2:0] OpAdd = 3'b010;
    localparam logic [2:0] OpSlt = 3'b011;
    localparam logic [2:0] OpMul = 3'b100;
    localparam logic [2:0] OpXor = 3'b101;

    typedef enum logic {
        StIdle,
        StMul
    } state_e;

    state_e state_q, state_d;

    // Multiplier datapath
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic [2*WIDTH-1:0] mcand_q, mcand_d;
    logic [WIDTH-1:0]   mplier_q, mplier_d;
    logic [2*WIDTH-1:0] acc_q, acc_d;
    logic [2*WIDTH-1:0] acc_step;
    logic               mul_last;

    // Output registers
    logic             out_valid_q, out_valid_d;
    logic [WIDTH-1:0] result_q, result_d;
    logic             carry_q, carry_d;
    logic             ovf_q, ovf_d;
    logic             zero_q, zero_d;

    // Single-cycle ALU
    logic [WIDTH-1:0] a_op, b_op;
    logic [WIDTH:0]   add_sum;
    logic             add_cin_msb;
    logic             add_ovf;
    logic [WIDTH-1:0] sub_diff;
    logic             sub_ovf;
    logic             slt_bit;
    logic [WIDTH-1:0] alu_res;
    logic             alu_c;
    logic             alu_v;

    // Value to be loaded into the output registers this cycle
    logic             load;
    logic [WIDTH-1:0] load_res;
    logic             load_c;
    logic             load_v;

    logic accept;

    assign in_ready = (state_q == StIdle) && (!out_valid_q || out_ready);
    assign accept   = in_valid && in_ready;
    assign busy     = (state_q == StMul);

    assign out_valid = out_valid_q;
    assign result    = result_q;
    assign CarryOut  = carry_q;
    assign Overflow  = ovf_q;
    assign Zero      = zero_q;

    // Operand preparation and adder / comparator
    always_comb begin
        a_op = AInvert ? ~a : a;
        b_op = BNegate ? ~b : b;

        add_sum     = {1'b0, a_op} + {1'b0, b_op} + {{WIDTH{1'b0}}, BNegate};
        // Sum MSB = a ^ b ^ carry-in, so the carry into the MSB falls out directly.
        add_cin_msb = add_sum[WIDTH-1] ^ a_op[WIDTH-1] ^ b_op[WIDTH-1];
        add_ovf     = add_cin_msb ^ add_sum[WIDTH];

        // SLT ignores AInvert/BNegate and always evaluates a - b as signed.
        sub_diff = a - b;
        sub_ovf  = (a[WIDTH-1] ^ b[WIDTH-1]) & (sub_diff[WIDTH-1] ^ a[WIDTH-1]);
        slt_bit  = sub_diff[WIDTH-1] ^ sub_ovf;
    end

    // Single-cycle result select; MUL and reserved opcodes yield zeros here
    always_comb begin
        alu_res = '0;
        alu_c   = 1'b0;
        alu_v   = 1'b0;
        case (Op)
            OpAnd: alu_res = a_op & b_op;
            OpOr:  alu_res = a_op | b_op;
            OpXor: alu_res = a_op ^ b_op;
            OpAdd: begin
                alu_res = add_sum[WIDTH-1:0];
                alu_c   = add_sum[WIDTH];
                alu_v   = add_ovf;
            end
            OpSlt: alu_res = {{(WIDTH-1){1'b0}}, slt_bit};
            default: ;
        endcase
    end

    // One shift-add step of the multiplier
    always_comb begin
        acc_step = acc_q + (mplier_q[0] ? mcand_q : '0);
        mul_last = (cnt_q == CNT_W'(WIDTH - 1));
    end

    // Control FSM: next state, multiplier updates and output-load selection
    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        mcand_d  = mcand_q;
        mplier_d = mplier_q;
        acc_d    = acc_q;
        load     = 1'b0;
        load_res = alu_res;
        load_c   = alu_c;
        load_v   = alu_v;

        unique case (state_q)
            StIdle: begin
                if (accept) begin
                    if (Op == OpMul) begin
                        state_d  = StMul;
                        mcand_d  = {{WIDTH{1'b0}}, a};
                        mplier_d = b;
                        acc_d    = '0;
                        cnt_d    = '0;
                    end else begin
                        load = 1'b1;
                    end
                end
            end
            StMul: begin
                acc_d    = acc_step;
                mcand_d  = mcand_q << 1;
                mplier_d = mplier_q >> 1;
                cnt_d    = cnt_q + CNT_W'(1);
                // The final step's sum is the product; load it on the same edge.
                if (mul_last) begin
                    state_d  = StIdle;
                    load     = 1'b1;
                    load_res = acc_step[WIDTH-1:0];
                    load_c   = |acc_step[2*WIDTH-1:WIDTH];
                    load_v   = 1'b0;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    // Output register next-state: load new result, or drop valid once consumed
    always_comb begin
        out_valid_d = out_valid_q;
        result_d    = result_q;
        carry_d     = carry_q;
        ovf_d       = ovf_q;
        zero_d      = zero_q;
        if (load) begin
            out_valid_d = 1'b1;
            result_d    = load_res;
            carry_d     = load_c;
            ovf_d       = load_v;
            zero_d      = ~|load_res;
        end else if (out_ready) begin
            out_valid_d = 1'b0;
        end
    end

    // FSM and multiplier state registers
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q  <= StIdle;
            cnt_q    <= '0;
            mcand_q  <= '0;
            mplier_q <= '0;
            acc_q    <= '0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            mcand_q  <= mcand_d;
            mplier_q <= mplier_d;
            acc_q    <= acc_d;
        end
    end

    // Output registers; Zero resets high to match the cleared result
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            out_valid_q <= 1'b0;
            result_q    <= '0;
            carry_q     <= 1'b0;
            ovf_q       <= 1'b0;
            zero_q      <= 1'b1;
        end else begin
            out_valid_q <= out_valid_d;
            result_q    <= result_d;
            carry_q     <= carry_d;
            ovf_q       <= ovf_d;
            zero_q      <= zero_d;
        end
    end

endmodule

// File: tb/tb_alu_pipe_nbit.sv
// Self-checking bench for alu_pipe_nbit (WIDTH=16): directed cases, backpressure,
// back-to-back issue, mid-multiply reset and randomized operations.

module tb_alu_pipe_nbit;

    localparam int W = 16;

    logic          clk = 1'b0;
    logic          reset;
    logic          in_valid;
    logic          in_ready;
    logic [W-1:0]  a;
    logic [W-1:0]  b;
    logic          AInvert;
    logic          BNegate;
    logic [2:0]    Op;
    logic          out_valid;
    logic          out_ready;
    logic [W-1:0]  result;
    logic          CarryOut;
    logic          Overflow;
    logic          Zero;
    logic          busy;

    int n_tests = 0;
    int n_fail  = 0;

    alu_pipe_nbit #(.WIDTH(W)) dut (
        .clk       (clk),
        .reset     (reset),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .a         (a),
        .b         (b),
        .AInvert   (AInvert),
        .BNegate   (BNegate),
        .Op        (Op),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .result    (result),
        .CarryOut  (CarryOut),
        .Overflow  (Overflow),
        .Zero      (Zero),
        .busy      (busy)
    );

    always #5 clk = ~clk;

    task automatic check_val(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
        end
    endtask

    // Reference model: returns {result, carry, overflow, zero}.
    function automatic logic [W+2:0] model(input logic [W-1:0] ta, input logic [W-1:0] tb_,
                                           input logic ai, input logic bn, input logic [2:0] op);
        logic [W-1:0]        ap, bp, r;
        logic signed [W-1:0] sa, sb;
        logic                c, v;
        int                  u, s;
        longint              p;
        ap = ai ? ~ta : ta;
        bp = bn ? ~tb_ : tb_;
        r  = '0;
        c  = 1'b0;
        v  = 1'b0;
        case (op)
            3'd0: r = ap & bp;
            3'd1: r = ap | bp;
            3'd5: r = ap ^ bp;
            3'd2: begin
                u  = int'(ap) + int'(bp) + int'(bn);
                r  = u[W-1:0];
                c  = (u > 65535);
                sa = ap;
                sb = bp;
                s  = int'(sa) + int'(sb) + int'(bn);
                v  = (s > 32767) || (s < -32768);
            end
            3'd3: begin
                sa = ta;
                sb = tb_;
                r  = (sa < sb) ? 16'd1 : 16'd0;
            end
            3'd4: begin
                p = longint'(ta) * longint'(tb_);
                r = p[W-1:0];
                c = ((p >> 16) != 0);
            end
            default: ;
        endcase
        return {r, c, v, (r == 0)};
    endfunction

    // Issue one bundle, wait for its result, hold it for `hold` cycles, then drain it.
    task automatic run_op(input logic [W-1:0] ta, input logic [W-1:0] tb_, input logic ai,
                          input logic bn, input logic [2:0] op, input int hold);
        logic [W+2:0] exp;
        int           cyc;
        int           busy_cnt;
        bit           seen;
        exp = model(ta, tb_, ai, bn, op);
        @(negedge clk);
        check_val("in_ready_idle", in_ready, 1);
        a = ta; b = tb_; AInvert = ai; BNegate = bn; Op = op;
        in_valid  = 1'b1;
        out_ready = 1'b0;
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        // Scribble operands: an accepted bundle must not depend on them any more.
        a = W'($urandom); b = W'($urandom); Op = 3'($urandom);
        cyc = 0; busy_cnt = 0; seen = 0;
        while (!seen && cyc < 40) begin
            @(negedge clk);
            cyc++;
            if (busy) busy_cnt++;
            if (out_valid) seen = 1;
        end
        check_val("out_valid_seen", seen, 1);
        check_val("latency", cyc, (op == 3'd4) ? 17 : 1);
        check_val("busy_cycles", busy_cnt, (op == 3'd4) ? 16 : 0);
        check_val("result_flags", {result, CarryOut, Overflow, Zero}, exp);
        for (int i = 0; i < hold; i++) begin
            in_valid = 1'b1;
            a = W'($urandom); b = W'($urandom); Op = 3'($urandom);
            @(negedge clk);
            check_val("hold_in_ready", in_ready, 0);
            check_val("hold_valid", out_valid, 1);
            check_val("hold_stable", {result, CarryOut, Overflow, Zero}, exp);
        end
        in_valid  = 1'b0;
        out_ready = 1'b1;
        @(negedge clk);
        out_ready = 1'b0;
        check_val("drained", out_valid, 0);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [W+2:0] bexp [4];
        logic [W-1:0] ta, tb_;
        logic         ai, bn;

        reset = 1'b1; in_valid = 1'b0; out_ready = 1'b0;
        a = '0; b = '0; AInvert = 1'b0; BNegate = 1'b0; Op = 3'd0;
        #1;
        check_val("rst_out_valid", out_valid, 0);
        check_val("rst_flags", {result, CarryOut, Overflow, Zero, busy}, {16'h0, 4'b0010});
        repeat (2) @(negedge clk);
        reset = 1'b0;
        @(negedge clk);
        check_val("post_rst_in_ready", in_ready, 1);
        check_val("post_rst_out_valid", out_valid, 0);

        // Directed cases
        run_op(16'h7FFF, 16'h0001, 1'b0, 1'b0, 3'd2, 0);
        run_op(16'h0005, 16'h0005, 1'b0, 1'b1, 3'd2, 0);
        run_op(16'hFFFF, 16'h0001, 1'b0, 1'b0, 3'd3, 0);
        run_op(16'h0001, 16'hFFFF, 1'b0, 1'b0, 3'd3, 0);
        run_op(16'h0100, 16'h0100, 1'b0, 1'b0, 3'd4, 0);
        run_op(16'h00FF, 16'h0003, 1'b0, 1'b0, 3'd4, 0);
        run_op(16'hA5A5, 16'h0FF0, 1'b1, 1'b0, 3'd5, 0);
        run_op(16'h1234, 16'hFFFF, 1'b0, 1'b0, 3'd6, 0);
        // Backpressure: consumer stalls for 5 cycles
        run_op(16'h1111, 16'h2222, 1'b0, 1'b0, 3'd2, 5);

        // Back-to-back ADDs with the consumer always ready
        out_ready = 1'b1;
        for (int k = 0; k < 5; k++) begin
            @(negedge clk);
            if (k > 0) begin
                check_val("b2b_valid", out_valid, 1);
                check_val("b2b_result", {result, CarryOut, Overflow, Zero}, bexp[k-1]);
            end
            if (k < 4) begin
                ta = W'($urandom); tb_ = W'($urandom);
                ai = 1'($urandom); bn = 1'($urandom);
                bexp[k] = model(ta, tb_, ai, bn, 3'd2);
                check_val("b2b_in_ready", in_ready, 1);
                a = ta; b = tb_; AInvert = ai; BNegate = bn; Op = 3'd2;
                in_valid = 1'b1;
            end else begin
                in_valid = 1'b0;
            end
        end
        @(negedge clk);
        check_val("b2b_drained", out_valid, 0);
        out_ready = 1'b0;

        // Reset in the middle of a multiply
        @(negedge clk);
        a = 16'h1234; b = 16'h5678; AInvert = 1'b0; BNegate = 1'b0; Op = 3'd4;
        in_valid = 1'b1;
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        repeat (8) @(negedge clk);
        check_val("mul_busy_mid", busy, 1);
        reset = 1'b1;
        #1;
        check_val("rst_mid_out_valid", out_valid, 0);
        check_val("rst_mid_busy", busy, 0);
        check_val("rst_mid_zero", Zero, 1);
        check_val("rst_mid_result", result, 0);
        @(negedge clk);
        reset = 1'b0;
        out_ready = 1'b1;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            if (out_valid) check_val("rst_no_stray_output", out_valid, 0);
        end
        out_ready = 1'b0;
        run_op(16'h0002, 16'h0003, 1'b0, 1'b0, 3'd2, 0);
        check_val("post_rst_add", result, 16'h0005);

        // Randomized operations with random consumer stalls
        for (int n = 0; n < 60; n++) begin
            run_op(W'($urandom), W'($urandom), 1'($urandom), 1'($urandom),
                   3'($urandom_range(0, 7)), int'($urandom_range(0, 3)));
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
